// File: rtl/range_pkg.sv
// Shared types and defaults for the range stream source and its FIFO.
package range_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/range_sample_fifo.sv
// Sample buffer: power-of-two circular FIFO with registered count/full/empty.
module range_sample_fifo #(
  parameter int WIDTH = range_pkg::DEF_WIDTH,
  parameter int DEPTH = range_pkg::DEF_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_n;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_n = count;
    case ({do_push, do_pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  // Storage carries no reset; only pointers and occupancy are control state.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      full  <= (count_n == CW'(DEPTH));
      empty <= (count_n == '0);
    end
  end

endmodule

// File: rtl/range_stream_source.sv
// Buffers a host-loaded burst and replays it as a go/finish-framed stream.
// Optional expected-range tracking is enabled with RANGE_SRC_EXPECT_EN.
module range_stream_source
  import range_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_en,
  input  logic                   start,
  output logic [WIDTH-1:0]       data_out,
  output logic                   go,
  output logic                   finish,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   err,
  output logic [WIDTH-1:0]       exp_range
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t           state;
  logic             first;
  logic             idle;
  logic             start_ok;
  logic             push;
  logic             pop;
  logic             last;
  logic             err_set;
  logic [WIDTH-1:0] head;

  assign idle     = (state == IDLE);
  assign start_ok = start && idle && (count >= CW'(2));
  // A write colliding with an accepted start is dropped so N stays as sampled.
  assign push     = wr_en && idle && !full && !start_ok;
  assign pop      = (state == PLAY) && !empty;
  assign last     = pop && (count == CW'(1));
  assign err_set  = (wr_en && !push) || (start && idle && !start_ok);

  range_sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      first    <= 1'b0;
      data_out <= '0;
      go       <= 1'b0;
      finish   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      err    <= err | err_set;
      go     <= 1'b0;
      finish <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state <= PLAY;
            busy  <= 1'b1;
            first <= 1'b1;
          end
        end
        PLAY: begin
          if (pop) begin
            data_out <= head;
            go       <= first;
            finish   <= last;
            first    <= 1'b0;
          end
          if (last || empty) state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RANGE_SRC_EXPECT_EN
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;
  logic [WIDTH-1:0] min_n;
  logic [WIDTH-1:0] max_n;

  // An empty buffer reseeds the running extremes from the incoming sample.
  always_comb begin
    min_n = (empty || (wr_data < min_q)) ? wr_data : min_q;
    max_n = (empty || (wr_data > max_q)) ? wr_data : max_q;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      min_q <= min_n;
      max_q <= max_n;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_range <= '0;
    end else if (push) begin
      exp_range <= max_n - min_n;
    end else if (state == DONE) begin
      exp_range <= '0;
    end
  end
`else
  assign exp_range = '0;
`endif

endmodule

// File: tb/tb_range_stream_source.sv
// Directed bench for range_stream_source: a vector table plus corner-case sequences.
module tb_range_stream_source;

  localparam int W = 16;
  localparam int D = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [W-1:0]  wr_data;
  logic          wr_en;
  logic          start;
  logic [W-1:0]  data_out;
  logic          go;
  logic          finish;
  logic          busy;
  logic          done;
  logic [3:0]    count;
  logic          full;
  logic          empty;
  logic          err;
  logic [W-1:0]  exp_range;

  int n_vec  = 0;
  int n_fail = 0;

  range_stream_source #(.WIDTH(W), .DEPTH(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .start     (start),
    .data_out  (data_out),
    .go        (go),
    .finish    (finish),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .err       (err),
    .exp_range (exp_range)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         start;
    logic         go;
    logic         finish;
    logic         done;
    logic         busy;
    logic [W-1:0] data_out;
    logic [3:0]   count;
    logic         err;
    logic [W-1:0] rng;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [W-1:0] ex(input logic [W-1:0] v);
`ifdef RANGE_SRC_EXPECT_EN
    return v;
`else
    return '0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic write(input logic [W-1:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called right after start was accepted; walks the n beats and the done pulse.
  task automatic frame(input string tag, input int n, input logic [W-1:0] v [8],
                       input logic [W-1:0] rng);
    for (int b = 0; b < n; b++) begin
      tick();
      chk({tag, "_data"}, 32'(data_out), 32'(v[b]));
      chk({tag, "_go"}, 32'(go), 32'(b == 0));
      chk({tag, "_finish"}, 32'(finish), 32'(b == n - 1));
      chk({tag, "_rng"}, 32'(exp_range), 32'(rng));
    end
    tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_empty_end"}, 32'(empty), 32'd1);
    chk({tag, "_go_end"}, 32'(go | finish), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v [8];

    // wr_en wr_data start | go fin done busy data cnt err rng
    tbl[0]  = '{1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd1, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 16'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd2, 1'b0, 16'd4};
    tbl[2]  = '{1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd3, 1'b0, 16'd7};
    tbl[3]  = '{1'b1, 16'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd4, 1'b0, 16'd7};
    tbl[4]  = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 4'd4, 1'b0, 16'd7};
    tbl[5]  = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd5, 4'd3, 1'b0, 16'd7};
    tbl[6]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd9, 4'd2, 1'b0, 16'd7};
    tbl[7]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 4'd1, 1'b0, 16'd7};
    tbl[8]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd7, 4'd0, 1'b0, 16'd7};
    tbl[9]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd7, 4'd0, 1'b0, 16'd0};
    tbl[10] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd7, 4'd0, 1'b0, 16'd0};

    reset = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0;
    tick(); tick();
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_flags", 32'({go, finish, busy, done, err, full}), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_rng", 32'(exp_range), 32'd0);
    reset = 1'b0;
    tick();

    // Table: load 5,9,2,7 and play them back.
    for (int i = 0; i < 11; i++) begin
      wr_en = tbl[i].wr_en; wr_data = tbl[i].wr_data; start = tbl[i].start;
      tick();
      wr_en = 1'b0; start = 1'b0;
      chk($sformatf("t%0d_go", i), 32'(go), 32'(tbl[i].go));
      chk($sformatf("t%0d_finish", i), 32'(finish), 32'(tbl[i].finish));
      chk($sformatf("t%0d_done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("t%0d_data", i), 32'(data_out), 32'(tbl[i].data_out));
      chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].count));
      chk($sformatf("t%0d_err", i), 32'(err), 32'(tbl[i].err));
      chk($sformatf("t%0d_rng", i), 32'(exp_range), 32'(ex(tbl[i].rng)));
    end

    // Single sample: start refused with error, buffer intact.
    write(16'd4);
    kick();
    chk("one_err", 32'(err), 32'd1);
    chk("one_busy", 32'(busy), 32'd0);
    tick();
    chk("one_go", 32'(go), 32'd0);
    chk("one_count", 32'(count), 32'd1);
    do_reset();
    chk("one_rst_err", 32'(err), 32'd0);

    // Fill to capacity, overflow write, then 8-beat playback.
    for (int i = 0; i < 8; i++) begin
      v[i] = W'(i + 1);
      write(v[i]);
    end
    chk("full_flag", 32'(full), 32'd1);
    chk("full_err0", 32'(err), 32'd0);
    write(16'd99);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    kick();
    frame("full", 8, v, ex(16'd7));
    do_reset();

    // Reset during the first beat.
    write(16'd1); write(16'd2); write(16'd3);
    kick();
    tick();
    chk("mid_go_pre", 32'(go), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_go", 32'(go | finish), 32'd0);
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("mid_idle", 32'(busy | go | finish), 32'd0);
    v[0] = 16'd20; v[1] = 16'd30;
    write(v[0]); write(v[1]);
    kick();
    frame("mid", 2, v, ex(16'd10));

    // Write collides with an accepted start.
    do_reset();
    write(16'd11); write(16'd12);
    chk("col_err0", 32'(err), 32'd0);
    wr_en = 1'b1; wr_data = 16'd13; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk("col_err", 32'(err), 32'd1);
    chk("col_count", 32'(count), 32'd2);
    v[0] = 16'd11; v[1] = 16'd12;
    frame("col", 2, v, ex(16'd1));
    chk("col_cnt_end", 32'(count), 32'd0);

    // Back-to-back frames with differing ranges.
    do_reset();
    v[0] = 16'd3; v[1] = 16'd3;
    write(v[0]); write(v[1]);
    kick();
    frame("bb1", 2, v, 16'd0);
    v[0] = 16'd10; v[1] = 16'd1;
    write(v[0]); write(v[1]);
    chk("bb2_rng_pre", 32'(exp_range), 32'(ex(16'd9)));
    kick();
    frame("bb2", 2, v, ex(16'd9));
    chk("bb_err", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // go and finish must never be seen together on any cycle.
  always @(negedge clock) begin
    if (go && finish) begin
      n_fail++;
      $display("FAIL go_finish_overlap: got 1, expected 0");
    end
  end

endmodule
